// File: rtl/usb_rx_controller.sv
// USB receive bit-path sequencer: SYNC detection, bit de-stuffing, LSB-first
// byte assembly and EOP/error detection around an external NRZI decoder.
module usb_rx_controller #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int STUFF_LIMIT    = 6,
  parameter int IDLE_BITS      = 7
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       rx_enable,
  input  logic       bit_strobe,
  input  logic       dp,
  input  logic       dm,
  input  logic       decoded_bit,
  output logic       nrzi_en,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_eop,
  output logic       rx_err,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [2:0] SYNC_MIN  = 3'(SYNC_MIN_ZEROS);
  localparam logic [2:0] STUFF_LIM = 3'(STUFF_LIMIT);
  localparam logic [2:0] IDLE_LAST = 3'(IDLE_BITS - 1);

  state_e     state_q, state_d;
  logic [2:0] zero_cnt_q, zero_cnt_d;
  logic [2:0] one_cnt_q, one_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [2:0] idle_cnt_q, idle_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_eop_q, rx_eop_d;
  logic       rx_err_q, rx_err_d;
  logic [7:0] next_byte;

  logic line_j, line_k, line_se0;
  assign line_j   =  dp & ~dm;
  assign line_k   = ~dp &  dm;
  assign line_se0 = ~dp & ~dm;

  // rx_valid/rx_eop/rx_err carry no handshake: each is a registered one-clk
  // pulse the cycle after the qualifying strobe, and the consumer must take it.
  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    one_cnt_d  = one_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_eop_d   = 1'b0;
    rx_err_d   = 1'b0;
    next_byte  = {decoded_bit, shift_q[7:1]};

    if (!rx_enable) begin
      state_d    = ST_IDLE;
      zero_cnt_d = '0;
      one_cnt_d  = '0;
      bit_cnt_d  = '0;
      idle_cnt_d = '0;
      shift_d    = '0;
      rx_data_d  = '0;
    end else if (bit_strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (line_k) begin
            state_d    = ST_SYNC;
            zero_cnt_d = '0;
          end
        end
        ST_SYNC: begin
          if (line_se0) begin
            state_d = ST_IDLE;
          end else if (!decoded_bit) begin
            if (zero_cnt_q != 3'd7) zero_cnt_d = zero_cnt_q + 3'd1;
          end else if (zero_cnt_q >= SYNC_MIN) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            one_cnt_d = 3'd1;
            shift_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (line_se0) begin
            state_d  = ST_EOP;
            rx_err_d = (bit_cnt_q != 3'd0);
          end else if (one_cnt_q == STUFF_LIM) begin
            // After a full run of ones the next bit must be the stuffed zero.
            if (!decoded_bit) begin
              one_cnt_d = '0;
            end else begin
              rx_err_d   = 1'b1;
              state_d    = ST_ERR;
              idle_cnt_d = '0;
            end
          end else begin
            shift_d   = next_byte;
            one_cnt_d = decoded_bit ? one_cnt_q + 3'd1 : 3'd0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d  = next_byte;
              rx_valid_d = 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (line_j) begin
            rx_eop_d = 1'b1;
            state_d  = ST_IDLE;
          end else if (line_k) begin
            rx_err_d   = 1'b1;
            state_d    = ST_ERR;
            idle_cnt_d = '0;
          end
        end
        ST_ERR: begin
          if (line_j) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d    = ST_IDLE;
              idle_cnt_d = '0;
            end else begin
              idle_cnt_d = idle_cnt_q + 3'd1;
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      zero_cnt_q <= '0;
      one_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_eop_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      one_cnt_q  <= one_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_eop_q   <= rx_eop_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign nrzi_en   = (state_q == ST_SYNC) || (state_q == ST_DATA);
  assign rx_active = (state_q == ST_DATA) || (state_q == ST_EOP);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_eop    = rx_eop_q;
  assign rx_err    = rx_err_q;
  assign state_dbg = state_q;

endmodule
